// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet transmit path.
package eth_pkg;

    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} tx_arb_state_t;

    localparam int ETH_BYTE_W    = 8;
    localparam int ETH_MAX_FRAME = 1518;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_idx, with wrap-around.
module rr_pick
    import eth_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_SRC-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        // Scan offsets 1..N_SRC so the previous owner has lowest priority.
        for (int i = 1; i <= N_SRC; i++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (j == (int'(last_idx) + i) % N_SRC && req[j] && !found) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign pick_idx = IDX_W'(onehot_to_idx(8'(pick)));
    assign any      = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC byte stream, with
// inter-frame gap enforcement and truncation of frames longer than MAX_LEN.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int IFG_CYCLES = 48,
    parameter int MAX_LEN    = ETH_MAX_FRAME
) (
    input  logic                        clk_mac,
    input  logic                        rst,
    input  logic [ETH_BYTE_W*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [N_SRC-1:0]            src_last,
    output logic [N_SRC-1:0]            src_ready,
    output logic [ETH_BYTE_W-1:0]       tx_data,
    output logic                        tx_valid,
    output logic                        tx_last,
    output logic                        tx_err,
    input  logic                        tx_ready,
    output logic [N_SRC-1:0]            grant,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int CNT_W = 11;
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam tx_arb_state_t POST_FRAME = (IFG_CYCLES > 0) ? GAP : IDLE;

    tx_arb_state_t         state_q, state_d;
    logic [N_SRC-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_idx_q, last_idx_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [GAP_W-1:0]      gap_q, gap_d;

    logic [N_SRC-1:0]      pick;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [ETH_BYTE_W-1:0] g_data;
    logic                  g_valid, g_last, hs, at_max;

    rr_pick #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_rr_pick (
        .req      (src_valid),
        .last_idx (last_idx_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // last_idx_q doubles as the owner index while a frame is in flight.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (int'(last_idx_q) == i) begin
                g_data  = src_data[i*ETH_BYTE_W +: ETH_BYTE_W];
                g_valid = src_valid[i];
                g_last  = src_last[i];
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        count_d    = count_q;
        gap_d      = gap_q;
        tx_data    = '0;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;
        tx_err     = 1'b0;
        src_ready  = '0;
        hs         = 1'b0;
        at_max     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = XFER;
                    grant_d    = pick;
                    last_idx_d = pick_idx;
                    count_d    = '0;
                end
            end
            XFER: begin
                at_max    = (count_q == CNT_LAST) && !g_last;
                tx_data   = g_data;
                tx_valid  = g_valid;
                tx_last   = g_valid && (g_last || at_max);
                tx_err    = g_valid && at_max;
                src_ready = grant_q & {N_SRC{tx_ready}};
                hs        = g_valid && tx_ready;
                if (hs) begin
                    count_d = count_q + 1'b1;
                    if (g_last) begin
                        state_d = POST_FRAME;
                        grant_d = '0;
                        gap_d   = GAP_LOAD;
                    end else if (at_max) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                src_ready = grant_q;
                if (g_valid && g_last) begin
                    state_d = POST_FRAME;
                    grant_d = '0;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_idx_q <= IDX_W'(N_SRC - 1);
            count_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: three instances cover default, MAX_LEN=16 and IFG_CYCLES=0.
module tb_eth_tx_arbiter;

    localparam int NS = 2;
    localparam int ND = 3;

    logic clk_mac = 1'b0;
    logic rst;
    always #5 clk_mac = ~clk_mac;

    logic [15:0] src_data  [ND];
    logic [1:0]  src_valid [ND];
    logic [1:0]  src_last  [ND];
    logic [1:0]  src_ready [ND];
    logic [1:0]  grant     [ND];
    logic [7:0]  tx_data   [ND];
    logic        tx_valid  [ND];
    logic        tx_last   [ND];
    logic        tx_err    [ND];
    logic        tx_ready  [ND];
    logic        busy      [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        eth_tx_arbiter #(
            .N_SRC      (NS),
            .IFG_CYCLES (k == 2 ? 0 : 48),
            .MAX_LEN    (k == 1 ? 16 : 1518)
        ) u_dut (
            .clk_mac   (clk_mac),
            .rst       (rst),
            .src_data  (src_data[k]),
            .src_valid (src_valid[k]),
            .src_last  (src_last[k]),
            .src_ready (src_ready[k]),
            .tx_data   (tx_data[k]),
            .tx_valid  (tx_valid[k]),
            .tx_last   (tx_last[k]),
            .tx_err    (tx_err[k]),
            .tx_ready  (tx_ready[k]),
            .grant     (grant[k]),
            .busy      (busy[k])
        );
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
        logic [1:0] grant;
        int         cyc;
    } rx_t;

    rx_t rx_q[$];
    int  cyc = 0;
    always @(posedge clk_mac) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int s_len[NS], s_frames[NS], s_pos[NS], s_fno[NS];
    int rdy_mode = 0;
    bit bp_chk = 1'b0;
    int mirror_err = 0;
    int err_wo_last = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int s, input int f, input int k);
        return 8'(128 * s + 16 * f + k);
    endfunction

    task automatic drive(input int d);
        for (int s = 0; s < NS; s++) begin
            logic v;
            v = s_frames[s] > 0;
            src_valid[d][s]       = v;
            src_last[d][s]        = v && (s_pos[s] == s_len[s] - 1);
            src_data[d][8*s +: 8] = v ? exp_byte(s, s_fno[s], s_pos[s]) : 8'h00;
        end
    endtask

    task automatic start(input int s, input int len, input int frames);
        s_len[s]    = len;
        s_frames[s] = frames;
        s_pos[s]    = 0;
        s_fno[s]    = 0;
    endtask

    // One clock: sample at negedge, advance source models after the edge.
    task automatic step(input int d);
        logic [NS-1:0] acc;
        @(negedge clk_mac);
        if (tx_valid[d] && tx_ready[d])
            rx_q.push_back('{tx_data[d], tx_last[d], tx_err[d], grant[d], cyc});
        if (tx_err[d] && !tx_last[d]) err_wo_last++;
        if (bp_chk && grant[d][0] && s_frames[0] > 0 && src_ready[d] != {1'b0, tx_ready[d]})
            mirror_err++;
        acc = src_valid[d] & src_ready[d];
        @(posedge clk_mac);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (acc[s]) begin
                s_pos[s]++;
                if (s_pos[s] == s_len[s]) begin
                    s_pos[s] = 0;
                    s_fno[s]++;
                    s_frames[s]--;
                end
            end
        end
        tx_ready[d] = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        drive(d);
    endtask

    task automatic run(input int d, input string tag, input int budget);
        int n;
        n = 0;
        while ((s_frames[0] > 0 || s_frames[1] > 0 || busy[d]) && n < budget) begin
            step(d);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int s = 0; s < NS; s++) start(s, 1, 0);
        for (int d = 0; d < ND; d++) begin
            drive(d);
            tx_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk_mac);
        #1 rst = 1'b0;
        @(posedge clk_mac);
        #1;
    endtask

    initial begin
        int errs, t_req, n;

        rst = 1'b1;
        for (int s = 0; s < NS; s++) start(s, 1, 0);
        for (int d = 0; d < ND; d++) begin
            drive(d);
            tx_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk_mac);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk_mac);
        check("rst_grant", grant[0], 0);
        check("rst_txvalid", tx_valid[0], 0);
        check("rst_srcready", src_ready[0], 0);
        for (int d = 0; d < ND; d++) check($sformatf("rst_busy%0d", d), busy[d], 0);
        @(posedge clk_mac);
        #1;

        // Single source, 64 bytes
        rx_q.delete();
        rdy_mode = 0;
        tx_ready[0] = 1'b1;
        start(0, 64, 1);
        drive(0);
        t_req = cyc;
        run(0, "single", 400);
        check("single_len", rx_q.size(), 64);
        errs = 0;
        foreach (rx_q[i])
            if (rx_q[i].data != exp_byte(0, 0, i) || rx_q[i].last != (i == 63) || rx_q[i].err) errs++;
        check("single_data", errs, 0);
        check("single_grant", rx_q[0].grant, 2'b01);
        check("single_latency", rx_q[0].cyc - t_req, 1);

        // Contention: 3 frames each, src0 first after reset, then alternating
        do_reset();
        rx_q.delete();
        tx_ready[0] = 1'b1;
        start(0, 8, 3);
        start(1, 8, 3);
        drive(0);
        run(0, "cont", 800);
        check("cont_len", rx_q.size(), 48);
        errs = 0;
        for (int fi = 0; fi < 6; fi++) begin
            check($sformatf("cont_grant%0d", fi), rx_q[fi*8].grant, (fi % 2 == 0) ? 2'b01 : 2'b10);
            for (int k = 0; k < 8; k++)
                if (rx_q[fi*8+k].data != exp_byte(fi % 2, fi / 2, k) || rx_q[fi*8+k].last != (k == 7)) errs++;
            if (fi > 0)
                check($sformatf("cont_gap%0d", fi), rx_q[fi*8].cyc - rx_q[fi*8-1].cyc - 1, 49);
        end
        check("cont_data", errs, 0);

        // Backpressure: tx_ready 1-on / 2-off, 20-byte frame
        rx_q.delete();
        rdy_mode = 1;
        bp_chk = 1'b1;
        mirror_err = 0;
        tx_ready[0] = (cyc % 3 == 0);
        start(0, 20, 1);
        drive(0);
        run(0, "bp", 600);
        bp_chk = 1'b0;
        rdy_mode = 0;
        check("bp_len", rx_q.size(), 20);
        errs = 0;
        foreach (rx_q[i])
            if (rx_q[i].data != exp_byte(0, 0, i) || rx_q[i].last != (i == 19)) errs++;
        check("bp_data", errs, 0);
        check("bp_mirror", mirror_err, 0);

        // Truncation at MAX_LEN=16: src1 sends 40 bytes
        rx_q.delete();
        tx_ready[1] = 1'b1;
        start(1, 40, 1);
        drive(1);
        run(1, "trunc", 400);
        check("trunc_len", rx_q.size(), 16);
        errs = 0;
        foreach (rx_q[i])
            if (rx_q[i].data != exp_byte(1, 0, i) || rx_q[i].last != (i == 15) || rx_q[i].err != (i == 15)) errs++;
        check("trunc_data", errs, 0);
        check("trunc_last_err", {rx_q[15].last, rx_q[15].err}, 2'b11);
        check("trunc_grant", rx_q[0].grant, 2'b10);
        check("trunc_drained", s_pos[1] + s_frames[1], 0);

        // IFG_CYCLES=0: two back-to-back frames from src0
        rx_q.delete();
        tx_ready[2] = 1'b1;
        start(0, 5, 2);
        drive(2);
        run(2, "ifg0", 200);
        check("ifg0_len", rx_q.size(), 10);
        errs = 0;
        foreach (rx_q[i])
            if (rx_q[i].data != exp_byte(0, i / 5, i % 5) || rx_q[i].last != (i % 5 == 4)) errs++;
        check("ifg0_data", errs, 0);
        check("ifg0_idle", rx_q[5].cyc - rx_q[4].cyc - 1, 1);

        // Reset after byte 10 of 30
        rx_q.delete();
        tx_ready[0] = 1'b1;
        start(0, 30, 1);
        drive(0);
        n = 0;
        while (rx_q.size() < 10 && n < 200) begin
            step(0);
            n++;
        end
        check("rstmid_reach", rx_q.size(), 10);
        check("rstmid_pre_valid", tx_valid[0], 1);
        rst = 1'b1;
        #1;
        check("rstmid_valid", tx_valid[0], 0);
        check("rstmid_grant", grant[0], 0);
        check("rstmid_busy", busy[0], 0);
        check("rstmid_ready", src_ready[0], 0);
        @(posedge clk_mac);
        #1 rst = 1'b0;
        start(0, 1, 0);
        drive(0);
        rx_q.delete();
        start(1, 4, 1);
        drive(0);
        run(0, "rstmid_after", 200);
        check("rstmid_after_len", rx_q.size(), 4);
        check("rstmid_after_grant", rx_q[0].grant, 2'b10);
        errs = 0;
        foreach (rx_q[i])
            if (rx_q[i].data != exp_byte(1, 0, i) || rx_q[i].last != (i == 3)) errs++;
        check("rstmid_after_data", errs, 0);

        check("err_without_last", err_wo_last, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
